grant_scheduler8: RTL and testbench

GRANT_SCHEDULER8 -- requirements
Module: grant_scheduler8

---
 rtl/grant_scheduler8_pkg.sv | 27 ++
 rtl/decoder3to8.sv | 11 +
 rtl/grant_scheduler8.sv | 111 +++++++++++
 tb/tb_grant_scheduler8.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/grant_scheduler8_pkg.sv
// Shared constants and the rotating-priority pick helper for grant_scheduler8.
package grant_scheduler8_pkg;

    localparam int unsigned NUM_REQ      = 8;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned HOLD_MAX_DEF = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // First set request at or above ptr, wrapping; ptr itself when nothing is set.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        pick = ptr;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/decoder3to8.sv
// Shared 3-to-8 one-hot decoder.
module decoder3to8
    import grant_scheduler8_pkg::*;
(
    input  logic [IDX_W-1:0]   sel,
    output logic [NUM_REQ-1:0] dec
);

    assign dec = NUM_REQ'(1) << sel;

endmodule

// File: rtl/grant_scheduler8.sv
// Eight-way round-robin grant holder with one idle cycle per release.
// Define ARB_TIMEOUT_EN to bound tenure at HOLD_MAX cycles (tmo pulses on forced release).
module grant_scheduler8
    import grant_scheduler8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [NUM_REQ-1:0] gnt,
    output logic               tmo
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [0:0]         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               vld_nxt;
    logic               tmo_nxt;
    logic [IDX_W-1:0]   pick_c;
    logic [NUM_REQ-1:0] dec_c;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
`else
    logic               unused_hold;
    assign unused_hold = ^HOLD_LAST;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
            tmo     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_vld <= vld_nxt;
            gnt_idx <= idx_nxt;
            tmo     <= tmo_nxt;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= cnt_nxt;
`endif
        end
    end

    // Arbitration in IDLE, hold/release decision in GRANT
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        vld_nxt   = gnt_vld;
        tmo_nxt   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_nxt   = hold_cnt;
`endif
        pick_c    = rr_pick(req, ptr);

        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_GRANT;
                    idx_nxt   = pick_c;
                    vld_nxt   = 1'b1;
                    ptr_nxt   = pick_c + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            ST_GRANT: begin
                // Voluntary release wins over a coincident timeout
                if (!req[gnt_idx]) begin
                    state_nxt = ST_IDLE;
                    vld_nxt   = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                    vld_nxt   = 1'b0;
                    tmo_nxt   = 1'b1;
                end else begin
                    cnt_nxt   = hold_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    decoder3to8 u_dec (
        .sel (gnt_idx),
        .dec (dec_c)
    );

    assign gnt = dec_c & {NUM_REQ{gnt_vld}};

endmodule

// File: tb/tb_grant_scheduler8.sv
// Self-checking bench for grant_scheduler8: directed scenarios plus randomized traffic vs a behavioural model.
module tb_grant_scheduler8;
    import grant_scheduler8_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       tmo;

    int n_assert = 0;
    int n_fail   = 0;

    grant_scheduler8 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt     (gnt),
        .tmo     (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the grant, whose turn is next, how long the owner has held it
    int m_vld  = 0;
    int m_idx  = 0;
    int m_ptr  = 0;
    int m_tmo  = 0;
    int m_ten  = 0;
    bit m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_vld = 0; m_idx = 0; m_ptr = 0; m_tmo = 0; m_ten = 0;
            m_live = 1'b1;
        end else if (m_vld == 0) begin
            bit found;
            found = 1'b0;
            m_tmo = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && req[(m_ptr + k) % 8]) begin
                    found = 1'b1;
                    m_idx = (m_ptr + k) % 8;
                end
            end
            if (found) begin
                m_vld = 1;
                m_ptr = (m_idx + 1) % 8;
                m_ten = 1;
            end
        end else if (!req[m_idx]) begin
            m_vld = 0;
            m_tmo = 0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_ten == int'(HOLD_MAX_DEF)) begin
            m_vld = 0;
            m_tmo = 1;
        end
`endif
        else begin
            m_ten++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            check("model_vld", 32'(gnt_vld), 32'(m_vld));
            check("model_idx", 32'(gnt_idx), 32'(m_idx));
            check("model_gnt", 32'(gnt), (m_vld != 0) ? (32'(1) << m_idx) : 32'(0));
            check("model_tmo", 32'(tmo), 32'(m_tmo));
            check("onehot", 32'($countones(gnt) > 1), 32'(0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp;
        int mode;
        rst = 1'b1;
        req = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            check("idle_gnt", 32'(gnt), 32'h00);
            check("idle_vld", 32'(gnt_vld), 32'(0));
            check("idle_tmo", 32'(tmo), 32'(0));
        end

        // 0x81: requester 0 first, then 7 after one idle cycle
        do_reset();
        req = 8'h81;
        @(negedge clk);
        check("r81_first_gnt", 32'(gnt), 32'h01);
        check("r81_first_idx", 32'(gnt_idx), 32'(0));
        req = 8'h80;
        @(negedge clk);
        check("r81_idle_gnt", 32'(gnt), 32'h00);
        check("r81_idle_vld", 32'(gnt_vld), 32'(0));
        check("r81_idle_idx", 32'(gnt_idx), 32'(0));
        @(negedge clk);
        check("r81_second_gnt", 32'(gnt), 32'h80);
        check("r81_second_idx", 32'(gnt_idx), 32'(7));

        // All requesting: rotation 0..7,0 with a gap after each 3-cycle tenure
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp = i % 8;
            @(negedge clk);
            check("rot_vld", 32'(gnt_vld), 32'(1));
            check("rot_idx", 32'(gnt_idx), 32'(exp));
            @(negedge clk);
            @(negedge clk);
            check("rot_hold_gnt", 32'(gnt), 32'(1) << exp);
            req = 8'hFF & ~(8'(1) << exp);
            @(negedge clk);
            check("rot_gap_vld", 32'(gnt_vld), 32'(0));
            check("rot_gap_gnt", 32'(gnt), 32'h00);
            req = 8'hFF;
        end

        // Reset during a grant revokes it and restores pointer 0
        do_reset();
        req = 8'h20;
        @(negedge clk);
        check("rst_owner_idx", 32'(gnt_idx), 32'(5));
        rst = 1'b1;
        req = 8'h30;
        @(negedge clk);
        rst = 1'b0;
        check("rst_revoke_gnt", 32'(gnt), 32'h00);
        check("rst_revoke_vld", 32'(gnt_vld), 32'(0));
        check("rst_revoke_idx", 32'(gnt_idx), 32'(0));
        @(negedge clk);
        check("rst_regrant_idx", 32'(gnt_idx), 32'(4));
        check("rst_regrant_gnt", 32'(gnt), 32'h10);

        // Long hold of requester 2
        do_reset();
        req = 8'h04;
`ifdef ARB_TIMEOUT_EN
        repeat (HOLD_MAX_DEF) begin
            @(negedge clk);
            check("tmo_hold_gnt", 32'(gnt), 32'h04);
            check("tmo_hold_tmo", 32'(tmo), 32'(0));
        end
        @(negedge clk);
        check("tmo_pulse_tmo", 32'(tmo), 32'(1));
        check("tmo_pulse_gnt", 32'(gnt), 32'h00);
        @(negedge clk);
        check("tmo_regrant_gnt", 32'(gnt), 32'h04);
        check("tmo_regrant_tmo", 32'(tmo), 32'(0));
`else
        repeat (100) begin
            @(negedge clk);
            check("hold_gnt", 32'(gnt), 32'h04);
            check("hold_tmo", 32'(tmo), 32'(0));
        end
`endif

        // Randomized traffic with occasional reset
        req = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 63) == 0);
            mode = int'($urandom_range(0, 19));
            if (mode < 5)       req = 8'($urandom);
            else if (mode < 7)  req = 8'h00;
            else if (mode < 12) req = req ^ (8'(1) << $urandom_range(0, 7));
        end

        rst = 1'b0;
        req = 8'h00;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
